// File: rtl/fetch_sequencer.sv
// Sweeps the two-bank fetch datapath address by address, parity-checks every word
// and hands each one to a downstream consumer over a valid/ready stream.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LAST_ADDR   = 15,
  parameter bit          ODD_PARITY  = 1'b0,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] count_o,
  input  logic [DATA_W-1:0] num_i,
  input  logic              parity_i,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count
);

  localparam int unsigned ERR_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_count;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data;
  logic              r_par_ok;
  logic              w_par_ok;
  logic              r_valid;
  logic              w_valid;
  logic              r_busy;
  logic              r_done;
  logic [ERR_W-1:0]  r_err;
  logic [ERR_W-1:0]  w_err;
  logic              w_word_ok;

  assign w_word_ok = ((^{num_i, parity_i}) == ODD_PARITY);

  // State and datapath registers; busy/done are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_data   <= '0;
      r_par_ok <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_data   <= w_data;
      r_par_ok <= w_par_ok;
      r_valid  <= w_valid;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      r_err    <= w_err;
    end
  end

  // Next-state and next-value logic; abort always beats a same-cycle handshake.
  always_comb begin
    w_next   = r_state;
    w_count  = r_count;
    w_data   = r_data;
    w_par_ok = r_par_ok;
    w_valid  = r_valid;
    w_err    = r_err;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_count = '0;
          w_err   = '0;
          w_next  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_valid = 1'b0;
          w_next  = S_IDLE;
        end else begin
          w_data   = num_i;
          w_par_ok = w_word_ok;
          w_valid  = 1'b1;
          if (!w_word_ok) begin
            w_err = r_err + ERR_W'(1);
          end
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (abort) begin
          w_valid = 1'b0;
          w_next  = S_IDLE;
        end else if (out_ready) begin
          w_valid = 1'b0;
          if ((r_count == LAST) || (STOP_ON_ERR && !r_par_ok)) begin
            w_next = S_DONE;
          end else begin
            w_count = r_count + ADDR_W'(1);
            w_next  = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_valid = 1'b0;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign count_o    = r_count;
  assign out_data   = r_data;
  assign out_par_ok = r_par_ok;
  assign out_valid  = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_count  = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scenario table plus randomized sweeps
// checked against a transaction-level model of the fetch memory and sweep rules.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       abort_r;
  logic       ready_r;

  logic [3:0] cnt_w   [3];
  logic [7:0] num_w   [3];
  logic       par_w   [3];
  logic [7:0] data_w  [3];
  logic       ok_w    [3];
  logic       valid_w [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [4:0] err_w   [3];

  logic [7:0] mem_num [16];
  logic       mem_par [16];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: odd parity, 2: stop on first error.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign num_w[g] = mem_num[cnt_w[g]];
    assign par_w[g] = mem_par[cnt_w[g]];
    fetch_sequencer #(
      .ADDR_W(4), .DATA_W(8), .LAST_ADDR(15),
      .ODD_PARITY(g == 1), .STOP_ON_ERR(g == 2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .abort(abort_r),
      .count_o(cnt_w[g]), .num_i(num_w[g]), .parity_i(par_w[g]),
      .out_data(data_w[g]), .out_par_ok(ok_w[g]), .out_valid(valid_w[g]),
      .out_ready(ready_r), .busy(busy_w[g]), .done(done_w[g]), .err_count(err_w[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit word_bad(input int inst, input int a);
    return (^{mem_num[a], mem_par[a]}) != (inst == 1);
  endfunction

  function automatic int bad_upto(input int inst, input int last);
    int n = 0;
    for (int a = 0; a <= last; a++) if (word_bad(inst, a)) n++;
    return n;
  endfunction

  // Beats accepted before the sweep ends, from the sweep rules alone.
  function automatic int exp_beats(input int inst, input int abort_addr);
    for (int a = 0; a < 16; a++) begin
      if (a == abort_addr) return a;
      if (inst == 2 && word_bad(inst, a)) return a + 1;
    end
    return 16;
  endfunction

  task automatic load_mem(input logic [15:0] mask);
    for (int a = 0; a < 16; a++) begin
      mem_num[a] = 8'($urandom);
      mem_par[a] = (^mem_num[a]) ^ mask[a];
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: five stall cycles at address 9.
  task automatic run_sweep(input int inst, input int mode, input int abort_addr, input bit mid_start,
                           output int beats, output int err_final, output bit saw_done,
                           output int done_edge);
    int idx, since, bp, cyc;
    bit ended, done_due, ab, hs;
    idx = 0; since = 1; bp = 0; cyc = 1;
    ended = 0; done_due = 0;
    beats = 0; err_final = -1; saw_done = 0; done_edge = -1;
    @(negedge clk); start_v[inst] = 1'b1;
    @(negedge clk); start_v[inst] = 1'b0;
    while (!ended && cyc < 200) begin
      chk("done", 32'(done_w[inst]), 32'(done_due));
      if (done_due) begin
        saw_done = 1; done_edge = cyc - 1; err_final = int'(err_w[inst]);
        chk("err_at_done", 32'(err_w[inst]), 32'(bad_upto(inst, idx)));
        @(negedge clk);
        chk("busy_after_done", 32'(busy_w[inst]), 32'(0));
        chk("done_one_cycle", 32'(done_w[inst]), 32'(0));
        ended = 1;
      end else begin
        ab = 0; hs = 0;
        chk("valid", 32'(valid_w[inst]), 32'(since >= 2));
        if (valid_w[inst]) begin
          chk("data", 32'(data_w[inst]), 32'(mem_num[idx]));
          chk("par_ok", 32'(ok_w[inst]), 32'(!word_bad(inst, idx)));
          chk("count", 32'(cnt_w[inst]), 32'(idx));
          chk("busy", 32'(busy_w[inst]), 32'(1));
          chk("err_run", 32'(err_w[inst]), 32'(bad_upto(inst, idx)));
          if (idx == abort_addr) begin
            abort_r = 1'b1; ready_r = 1'b1; ab = 1;
          end else if (mode == 1) begin
            ready_r = ($urandom_range(3, 0) != 0);
          end else if (mode == 2 && idx == 9 && bp < 5) begin
            ready_r = 1'b0; bp++;
          end else begin
            ready_r = 1'b1;
          end
          if (mid_start && idx == 4) start_v[inst] = 1'b1;
          hs = ready_r && !ab;
        end else begin
          ready_r = 1'($urandom_range(1, 0));
        end
        @(negedge clk); cyc++;
        start_v[inst] = 1'b0; abort_r = 1'b0;
        if (ab) begin
          err_final = int'(err_w[inst]);
          chk("abort_valid", 32'(valid_w[inst]), 32'(0));
          chk("abort_busy", 32'(busy_w[inst]), 32'(0));
          chk("abort_done", 32'(done_w[inst]), 32'(0));
          chk("abort_err_held", 32'(err_w[inst]), 32'(bad_upto(inst, idx)));
          @(negedge clk);
          chk("abort_no_done", 32'(done_w[inst]), 32'(0));
          ended = 1;
        end else if (hs) begin
          beats++; since = 1;
          if (idx == 15 || (inst == 2 && word_bad(inst, idx))) done_due = 1;
          else idx++;
        end else begin
          since++;
        end
      end
    end
    if (!ended) chk("sweep_timeout", 32'(0), 32'(1));
    ready_r = 1'b0;
  endtask

  typedef struct {
    int          inst;
    int          mode;
    logic [15:0] mask;
    int          abort_addr;
    bit          mid_start;
    int          exp_beats;
    int          exp_err;
    bit          exp_done;
    int          exp_done_edge;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int beats, errf, dedge, inst, ab, nb;
    bit sdone, aborted;
    logic [15:0] mask;

    tbl[0] = '{0, 0, 16'h0000, -1, 1'b0, 16,  0, 1'b1, 32};
    tbl[1] = '{0, 2, 16'h0000, -1, 1'b1, 16,  0, 1'b1, 37};
    tbl[2] = '{0, 0, 16'h1008, -1, 1'b0, 16,  2, 1'b1, 32};
    tbl[3] = '{2, 0, 16'h1008, -1, 1'b0,  4,  1, 1'b1,  8};
    tbl[4] = '{0, 0, 16'h1008,  7, 1'b0,  7,  1, 1'b0, -1};
    tbl[5] = '{1, 0, 16'h0000, -1, 1'b0, 16, 16, 1'b1, 32};
    tbl[6] = '{1, 0, 16'h1008, -1, 1'b0, 16, 14, 1'b1, 32};

    rst_n = 1'b0; start_v = '0; abort_r = 1'b0; ready_r = 1'b0;
    load_mem(16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(cnt_w[0]), 32'(0));
    chk("rst_data", 32'(data_w[0]), 32'(0));
    chk("rst_ok", 32'(ok_w[0]), 32'(0));
    chk("rst_valid", 32'(valid_w[0]), 32'(0));
    chk("rst_busy", 32'(busy_w[0]), 32'(0));
    chk("rst_done", 32'(done_w[0]), 32'(0));
    chk("rst_err", 32'(err_w[0]), 32'(0));
    rst_n = 1'b1;

    // Asynchronous reset while holding word 5.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; ready_r = 1'b1;
    for (int i = 0; i < 40 && !(valid_w[0] && cnt_w[0] == 4'd5); i++) @(negedge clk);
    chk("mid_reach_5", 32'(cnt_w[0]), 32'(5));
    ready_r = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(cnt_w[0]), 32'(0));
    chk("mid_rst_data", 32'(data_w[0]), 32'(0));
    chk("mid_rst_ok", 32'(ok_w[0]), 32'(0));
    chk("mid_rst_valid", 32'(valid_w[0]), 32'(0));
    chk("mid_rst_busy", 32'(busy_w[0]), 32'(0));
    chk("mid_rst_err", 32'(err_w[0]), 32'(0));
    @(negedge clk); rst_n = 1'b1;

    // start together with abort in IDLE stays idle.
    @(negedge clk); start_v[0] = 1'b1; abort_r = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; abort_r = 1'b0;
    chk("start_abort_idle", 32'(busy_w[0]), 32'(0));

    foreach (tbl[i]) begin
      load_mem(tbl[i].mask);
      run_sweep(tbl[i].inst, tbl[i].mode, tbl[i].abort_addr, tbl[i].mid_start,
                beats, errf, sdone, dedge);
      chk($sformatf("row%0d_beats", i), 32'(beats), 32'(tbl[i].exp_beats));
      chk($sformatf("row%0d_err", i), 32'(errf), 32'(tbl[i].exp_err));
      chk($sformatf("row%0d_done", i), 32'(sdone), 32'(tbl[i].exp_done));
      if (tbl[i].exp_done_edge >= 0)
        chk($sformatf("row%0d_done_edge", i), 32'(dedge), 32'(tbl[i].exp_done_edge));
    end

    for (int r = 0; r < 8; r++) begin
      inst = $urandom_range(2, 0);
      mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : -1;
      load_mem(mask);
      nb = exp_beats(inst, -1);
      aborted = (ab >= 0) && (ab < nb);
      run_sweep(inst, 1, ab, r[0], beats, errf, sdone, dedge);
      chk($sformatf("rnd%0d_beats", r), 32'(beats), 32'(exp_beats(inst, ab)));
      chk($sformatf("rnd%0d_done", r), 32'(sdone), 32'(!aborted));
      chk($sformatf("rnd%0d_err", r), 32'(errf),
          32'(bad_upto(inst, aborted ? ab : nb - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
